// File: rtl/mult_shift_add_if.sv
// Operand/result bundle for the shift-add multiplier.
// The master issues operands and St; the slave returns Product and step strobes.
interface mult_shift_add_if #(
    parameter int WIDTH = 8
);
    logic               St;
    logic               Sgn;
    logic [WIDTH-1:0]   Mcand;
    logic [WIDTH-1:0]   Mplier;
    logic [2*WIDTH-1:0] Product;
    logic               Idle;
    logic               Done;
    logic               Load;
    logic               Ad;
    logic               Sh;

    modport master (
        output St,
        output Sgn,
        output Mcand,
        output Mplier,
        input  Product,
        input  Idle,
        input  Done,
        input  Load,
        input  Ad,
        input  Sh
    );

    modport slave (
        input  St,
        input  Sgn,
        input  Mcand,
        input  Mplier,
        output Product,
        output Idle,
        output Done,
        output Load,
        output Ad,
        output Sh
    );
endinterface

// File: rtl/mult_shift_add.sv
// Sequential shift-add multiplier, signed via magnitude/sign split.
// One add cycle per multiplier one-bit, one shift cycle per bit.
module mult_shift_add #(
    parameter int WIDTH = 8
) (
    input logic              Clk,
    input logic              Rst,
    mult_shift_add_if.slave  bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] CALC  = 2'd1;
    localparam logic [1:0] SHIFT = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [2*WIDTH:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   mc_q, mc_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               neg_q, neg_d;

    logic [WIDTH-1:0]   mcand_mag;
    logic [WIDTH-1:0]   mplier_mag;
    logic [2*WIDTH-1:0] low;
    logic               last;
    logic               load, ad, sh;

    // -2^(WIDTH-1) negates to itself, which is its correct unsigned magnitude
    always_comb begin
        mcand_mag  = bus.Mcand;
        mplier_mag = bus.Mplier;
        if (bus.Sgn && bus.Mcand[WIDTH-1]) begin
            mcand_mag = -bus.Mcand;
        end
        if (bus.Sgn && bus.Mplier[WIDTH-1]) begin
            mplier_mag = -bus.Mplier;
        end
    end

    assign last = (cnt_q == CW'(WIDTH-1));

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        mc_d    = mc_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        load    = 1'b0;
        ad      = 1'b0;
        sh      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.St) begin
                    load    = 1'b1;
                    mc_d    = mcand_mag;
                    acc_d   = {{(WIDTH+1){1'b0}}, mplier_mag};
                    cnt_d   = '0;
                    neg_d   = bus.Sgn
                            & (bus.Mcand[WIDTH-1] ^ bus.Mplier[WIDTH-1]);
                    state_d = CALC;
                end
            end
            CALC: begin
                if (acc_q[0]) begin
                    ad = 1'b1;
                    acc_d[2*WIDTH:WIDTH] = acc_q[2*WIDTH:WIDTH]
                                         + {1'b0, mc_q};
                    state_d = SHIFT;
                end else begin
                    sh      = 1'b1;
                    acc_d   = acc_q >> 1;
                    cnt_d   = cnt_q + CW'(1);
                    state_d = last ? DONE : CALC;
                end
            end
            SHIFT: begin
                sh      = 1'b1;
                acc_d   = acc_q >> 1;
                cnt_d   = cnt_q + CW'(1);
                state_d = last ? DONE : CALC;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            mc_q    <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            mc_q    <= mc_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
        end
    end

    assign low         = acc_q[2*WIDTH-1:0];
    assign bus.Product = neg_q ? -low : low;
    assign bus.Idle    = (state_q == IDLE);
    assign bus.Done    = (state_q == DONE);
    // Reset wins over a same-cycle start, so hide the load strobe then
    assign bus.Load    = load & ~Rst;
    assign bus.Ad      = ad & ~Rst;
    assign bus.Sh      = sh & ~Rst;
endmodule

// File: tb/tb_mult_shift_add.sv
// Scoreboard bench for mult_shift_add: random and directed operands,
// arithmetic reference model, monitor-side product/latency/strobe checks.
module tb_mult_shift_add;
    localparam int W = 8;

    typedef struct {
        logic [2*W-1:0] prod;
        int             lat;
        int             adds;
    } exp_t;

    logic Clk;
    logic Rst;
    mult_shift_add_if #(.WIDTH(W)) bus ();

    mult_shift_add #(.WIDTH(W)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, req, $time);
        end
    endtask

    function automatic exp_t model(input logic sgn, input logic [W-1:0] a,
                                   input logic [W-1:0] b);
        exp_t e;
        logic signed [31:0] sa, sb_;
        logic [31:0] p;
        int mb;
        sa  = sgn ? 32'($signed(a)) : 32'(a);
        sb_ = sgn ? 32'($signed(b)) : 32'(b);
        p   = sa * sb_;
        mb  = (sb_ < 0) ? -sb_ : sb_;
        e.prod = p[2*W-1:0];
        e.adds = $countones(mb);
        e.lat  = 1 + W + e.adds;
        return e;
    endfunction

    // Monitor: pops the scoreboard on Done and checks step strobes every cycle
    int             cyc = 0;
    int             load_cyc = 0;
    int             adds = 0;
    logic           prev_done = 1'b0;
    logic           holding = 1'b0;
    logic [2*W-1:0] hold_val = '0;

    always @(negedge Clk) begin
        exp_t e;
        cyc++;
        if (Rst) begin
            holding = 1'b0;
        end else begin
            chk("strobe_excl",
                32'($countones({bus.Load, bus.Ad, bus.Sh}) <= 1), 32'd1);
            if (bus.Done)
                chk("done_width", 32'(prev_done), 32'd0);
            if (bus.Ad || bus.Sh || bus.Done)
                chk("idle_busy", 32'(bus.Idle), 32'd0);
            if (holding && !bus.Load)
                chk("prod_hold", 32'(bus.Product), 32'(hold_val));
            if (bus.Load) begin
                load_cyc = cyc;
                adds     = 0;
                holding  = 1'b0;
            end
            if (bus.Ad)
                adds++;
            if (bus.Done) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: got Done=1 expected none at %0t",
                             $time);
                end else begin
                    e = sb.pop_front();
                    chk("product", 32'(bus.Product), 32'(e.prod));
                    chk("latency", 32'(cyc - load_cyc), 32'(e.lat));
                    chk("add_steps", 32'(adds), 32'(e.adds));
                end
                holding  = 1'b1;
                hold_val = bus.Product;
            end
        end
        prev_done = bus.Done;
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while (!bus.Idle && n < 100) begin
            @(posedge Clk);
            #1;
            n++;
        end
        if (!bus.Idle)
            chk("idle_timeout", 32'(bus.Idle), 32'd1);
    endtask

    task automatic start_op(input logic sgn, input logic [W-1:0] a,
                            input logic [W-1:0] b);
        wait_idle();
        bus.St     = 1'b1;
        bus.Sgn    = sgn;
        bus.Mcand  = a;
        bus.Mplier = b;
        sb.push_back(model(sgn, a, b));
        @(posedge Clk);
        #1;
        bus.St = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(posedge Clk);
            #1;
            n++;
        end
        if (sb.size() != 0) begin
            chk("drain_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    task automatic run_op(input logic sgn, input logic [W-1:0] a,
                          input logic [W-1:0] b);
        start_op(sgn, a, b);
        drain();
    endtask

    initial begin
        int n;
        Rst        = 1'b1;
        bus.St     = 1'b0;
        bus.Sgn    = 1'b0;
        bus.Mcand  = '0;
        bus.Mplier = '0;
        repeat (2) @(posedge Clk);
        #1;
        Rst = 1'b0;
        chk("rst_idle", 32'(bus.Idle), 32'd1);
        chk("rst_strobes",
            32'({bus.Done, bus.Load, bus.Ad, bus.Sh}), 32'd0);
        chk("rst_product", 32'(bus.Product), 32'd0);

        run_op(1'b0, 8'd13, 8'd11);
        run_op(1'b0, 8'd255, 8'd255);
        run_op(1'b1, 8'hFD, 8'd5);
        run_op(1'b1, 8'h80, 8'h80);
        run_op(1'b1, 8'h00, 8'hF9);
        run_op(1'b0, 8'hFF, 8'h00);
        run_op(1'b1, 8'h80, 8'h7F);
        run_op(1'b1, 8'h7F, 8'h80);

        for (int i = 0; i < 40; i++) begin
            run_op(1'(($urandom)), 8'($urandom), 8'($urandom));
        end

        // St re-pulsed mid-operation must not start a second product
        start_op(1'b0, 8'd200, 8'd77);
        repeat (3) @(posedge Clk);
        #1;
        bus.St     = 1'b1;
        bus.Mcand  = 8'd3;
        bus.Mplier = 8'd3;
        @(posedge Clk);
        #1;
        bus.St = 1'b0;
        drain();
        repeat (5) @(posedge Clk);
        #1;

        // St held high: back-to-back operations
        wait_idle();
        bus.St     = 1'b1;
        bus.Sgn    = 1'b1;
        bus.Mcand  = 8'hF0;
        bus.Mplier = 8'h13;
        sb.push_back(model(1'b1, 8'hF0, 8'h13));
        sb.push_back(model(1'b1, 8'hF0, 8'h13));
        n = 0;
        while (sb.size() > 1 && n < 100) begin
            @(posedge Clk);
            #1;
            n++;
        end
        chk("held_first", 32'(sb.size()), 32'd1);
        @(posedge Clk);
        #1;
        bus.St = 1'b0;
        drain();

        // Reset mid-CALC abandons the operation
        start_op(1'b0, 8'd99, 8'd255);
        repeat (3) @(posedge Clk);
        #1;
        Rst = 1'b1;
        bus.St = 1'b1;
        sb.delete();
        @(posedge Clk);
        #1;
        Rst = 1'b0;
        bus.St = 1'b0;
        chk("midrst_idle", 32'(bus.Idle), 32'd1);
        chk("midrst_product", 32'(bus.Product), 32'd0);
        chk("midrst_done", 32'(bus.Done), 32'd0);
        repeat (25) @(posedge Clk);
        #1;

        run_op(1'b1, 8'hFF, 8'hFF);
        repeat (3) @(posedge Clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mult_shift_add.md
MULT_SHIFT_ADD -- requirements
Module: mult_shift_add

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; the clock port SHALL be named Clk and the reset port Rst.
REQ-002 Parameter WIDTH, default 8, SHALL set the operand width in bits; legal values are WIDTH >= 2.
REQ-003 Clk  input  1  rising-edge clock for all state.
REQ-004 Rst  input  1  synchronous active-high reset.
REQ-005 St  input  1  start request, sampled only in IDLE.
REQ-006 Sgn  input  1  mode select, sampled with St: 1 = two's-complement signed, 0 = unsigned.
REQ-007 Mcand  input  WIDTH  multiplicand, sampled with St.
REQ-008 Mplier  input  WIDTH  multiplier, sampled with St.
REQ-009 Product  output  2*WIDTH  result.
REQ-010 Idle  output  1  high in IDLE state.
REQ-011 Done  output  1  single-cycle completion strobe.
REQ-012 Load, Ad, Sh  output  1 each  status strobes: operand load, add step, shift step.

Function
REQ-013 The block SHALL be a shift-add sequential multiplier with FSM states IDLE, CALC, SHIFT and DONE.
REQ-014 Internal state SHALL consist of:
- ACC: 2*WIDTH+1 bits; the upper WIDTH+1 bits are the partial sum including carry, the lower WIDTH bits are the multiplier.
- MC: WIDTH-bit latched multiplicand magnitude.
- CNT: bit counter.
- NEG: result sign flag.
REQ-015 IDLE, St=1: Load=1; MC <= |Mcand|; ACC <= {0, |Mplier|}; CNT <= 0; NEG <= Sgn & (Mcand[MSB] ^ Mplier[MSB]); next state CALC.
- Magnitudes are taken only when Sgn=1; otherwise the raw operand values are used.
REQ-016 IDLE, St=0: no state change.
REQ-017 CALC, ACC[0]=1: Ad=1; upper part <= upper part + MC, with carry kept in the extra bit; next state SHIFT.
REQ-018 CALC, ACC[0]=0: Sh=1; ACC <= ACC >> 1 (logical); CNT <= CNT+1; next state DONE if CNT = WIDTH-1, else stay in CALC.
REQ-019 SHIFT: Sh=1; ACC <= ACC >> 1; CNT <= CNT+1; next state DONE if CNT = WIDTH-1, else CALC.
REQ-020 DONE: Done=1 for exactly one cycle; next state IDLE unconditionally. St is ignored in DONE.
REQ-021 Product SHALL equal the low 2*WIDTH bits of ACC when NEG=0, and their two's-complement negation when NEG=1.
REQ-022 ACC SHALL NOT change in DONE or IDLE, so Product holds its value from DONE until the next Load.
- Product value while busy is don't-care.
REQ-023 Latency from the cycle in which St is accepted to the Done cycle SHALL be 1 + WIDTH + k cycles, where k = number of ones in the multiplier magnitude.
REQ-024 St asserted in CALC, SHIFT or DONE SHALL be ignored; it is not queued.
REQ-025 St held high continuously SHALL start a new operation in every IDLE cycle.
REQ-026 Signed most-negative operands (-2^(WIDTH-1)) SHALL be handled exactly.
- Their magnitude 2^(WIDTH-1) fits in WIDTH unsigned bits.
REQ-027 A zero product with NEG=1 SHALL output all zeros.
REQ-028 Load, Ad and Sh SHALL each be high only in the states given above; at most one of Load, Ad, Sh SHALL be high in any cycle.
REQ-029 Idle SHALL be high if and only if the state is IDLE.

Reset
REQ-030 Rst=1 at a clock edge SHALL force state IDLE and clear ACC, MC, CNT and NEG to 0, regardless of current state.
- This applies mid-operation as well.
REQ-031 After reset: Idle=1; Done=Load=Ad=Sh=0; Product=0.
REQ-032 Rst SHALL take priority over St in the same cycle.

Verification (WIDTH=8)
REQ-033 Unsigned 13*11: Sgn=0, St pulsed one cycle -> Done 12 cycles after the St cycle; Product=16'h008F.
REQ-034 Unsigned 255*255 -> Done after 17 cycles; Product=16'hFE01 (exercises carry bit).
REQ-035 Signed cases:
- -3*5 -> Product=16'hFFF1.
- -128*-128 -> Product=16'h4000; Done after 10 cycles.
- 0*-7 -> Product=16'h0000.
REQ-036 Mplier=0, Mcand=8'hFF unsigned -> Done after 9 cycles; Product=0; Ad never asserted.
REQ-037 Busy-path checks:
- St re-pulsed during CALC -> ignored; Product equals the first operation's result.
- Rst pulsed mid-CALC -> next cycle Idle=1, Product=0, no Done.
REQ-038 Every test SHALL check the step strobes: Load/Ad/Sh mutual exclusion, Done exactly one cycle wide, and Product stable from Done until the next Load.
